// File: rtl/cbus_mem_responder.sv
// rtl/cbus_mem_responder.sv - CBus slave over word-addressed on-chip memory; optional beat stalls via CBUS_RESP_RANDOM_STALL_EN
package cbus_pkg;
   typedef logic [3:0] cbus_len_t;
   typedef enum logic { CBUS_BURST_FIXED = 1'b0, CBUS_BURST_INCR = 1'b1 } cbus_burst_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
      cbus_len_t   len;
      cbus_burst_t burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

module cbus_mem_responder
   import cbus_pkg::*;
#(
   parameter int SIZE_WORDS = 4096,
   parameter int LATENCY    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp
);
   localparam int AW = $clog2(SIZE_WORDS);

   typedef enum logic [1:0] { IDLE, WAIT, BEAT } state_t;

   state_t        state;
   logic [AW-1:0] index;
   logic [3:0]    lat_cnt;
   cbus_len_t     len_q;
   cbus_len_t     beat_cnt;
   logic          is_write_q;
   cbus_burst_t   burst_q;
   logic [31:0]   mem [SIZE_WORDS];
   logic          stall;
   logic          beat_fire;

`ifdef CBUS_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr;

   // x^16 + x^14 + x^13 + x^11 + 1, free-running so stalls are reproducible from reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   assign beat_fire = (state == BEAT) && !stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         index      <= '0;
         lat_cnt    <= 4'd0;
         len_q      <= 4'd0;
         beat_cnt   <= 4'd0;
         is_write_q <= 1'b0;
         burst_q    <= CBUS_BURST_FIXED;
      end else begin
         case (state)
            IDLE: begin
               if (creq.valid) begin
                  index      <= creq.addr[AW+1:2];
                  len_q      <= creq.len;
                  is_write_q <= creq.is_write;
                  burst_q    <= creq.burst;
                  beat_cnt   <= 4'd0;
                  lat_cnt    <= 4'(LATENCY);
                  state      <= (LATENCY == 0) ? BEAT : WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - 4'd1;
               if (lat_cnt <= 4'd1) state <= BEAT;
            end
            BEAT: begin
               if (!stall) begin
                  if (burst_q == CBUS_BURST_INCR) index <= index + 1'b1;
                  if (beat_cnt == len_q) begin
                     beat_cnt <= 4'd0;
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory is deliberately outside the reset domain: contents survive reset
   always_ff @(posedge clk) begin
      if (beat_fire && is_write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (creq.strobe[b]) mem[index][8*b +: 8] <= creq.data[8*b +: 8];
         end
      end
   end

   always_comb begin
      cresp = '0;
      if (beat_fire) begin
         cresp.ready = 1'b1;
         cresp.last  = (beat_cnt == len_q);
         if (!is_write_q) cresp.data = mem[index];
      end
   end

   logic unused_req_bits;
   assign unused_req_bits = ^{creq.size, creq.addr[31:AW+2], creq.addr[1:0]};

endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb/tb_cbus_mem_responder.sv - directed and scoreboard bench for cbus_mem_responder
module tb_cbus_mem_responder;
   import cbus_pkg::*;

   localparam int LAT = 2;
   localparam int NW  = 4096;

   logic       clk = 1'b0;
   logic       reset;
   cbus_req_t  creq;
   cbus_resp_t cresp;

   always #5 clk = ~clk;

   cbus_mem_responder #(.SIZE_WORDS(NW), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .creq  (creq),
      .cresp (cresp)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] model [NW];
   logic [31:0] wbuf [16];
   logic [3:0]  sbuf [16];
   logic [31:0] rbuf [16];
   int          got_lat;

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Entered and left at posedge+1 of an IDLE cycle, so successive calls are back-to-back
   task automatic burst(input logic w, input logic [31:0] a, input cbus_len_t len, input cbus_burst_t b);
      int cyc, nb, first_cyc, last_cyc;
      bit lastgood;
      logic [11:0] idx;
      creq.valid    = 1'b1;
      creq.is_write = w;
      creq.addr     = a;
      creq.len      = len;
      creq.burst    = b;
      creq.data     = wbuf[0];
      creq.strobe   = sbuf[0];
      @(posedge clk); #1;
      creq.valid = 1'b0;
      idx = a[13:2];
      cyc = 0; nb = 0; lastgood = 1'b1; got_lat = -1; first_cyc = 0; last_cyc = 0;
      while (nb <= int'(len) && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cresp.ready) begin
            if (got_lat < 0) begin
               got_lat   = cyc - 1;
               first_cyc = cyc;
            end
            last_cyc = cyc;
            rbuf[nb] = cresp.data;
            if (cresp.last !== (nb == int'(len))) lastgood = 1'b0;
            if (w) begin
               for (int k = 0; k < 4; k++)
                  if (sbuf[nb][k]) model[idx][8*k +: 8] = wbuf[nb][8*k +: 8];
            end else begin
               chk($sformatf("sb_read a=%h beat%0d", a, nb), cresp.data, model[idx]);
            end
            if (b == CBUS_BURST_INCR) idx = idx + 12'd1;
            nb++;
            @(posedge clk); #1;
            creq.data   = wbuf[nb % 16];
            creq.strobe = sbuf[nb % 16];
         end else if (cresp.last !== 1'b0 || cresp.data !== 32'h0) begin
            lastgood = 1'b0;
         end
      end
      chk("beat_count", nb, int'(len) + 1);
      chk("last_and_idle_outputs", {31'd0, lastgood}, 32'd1);
`ifndef CBUS_RESP_RANDOM_STALL_EN
      chk("first_beat_latency", got_lat, LAT);
      chk("beats_contiguous", last_cyc - first_cyc, int'(len));
`endif
   endtask

   initial begin
      int cnt, n_rand;
      creq  = '0;
      reset = 1'b1;
      for (int i = 0; i < NW; i++) model[i] = 32'hC0DE0000 | i;
      model[5]    = 32'hDEADBEEF;
      model[0]    = 32'h11223344;
      model[4095] = 32'hFACEFEED;
      for (int i = 0; i < NW; i++) dut.mem[i] = model[i];
      for (int i = 0; i < 16; i++) begin
         wbuf[i] = 32'h0;
         sbuf[i] = 4'hF;
      end

      vt[0]  = '{1'b0, 32'h0000_0014, 4'h0, 32'h0,         32'hDEADBEEF};
      vt[1]  = '{1'b1, 32'h0000_0014, 4'h3, 32'h0000CAFE,  32'h0};
      vt[2]  = '{1'b0, 32'h0000_0016, 4'h0, 32'h0,         32'hDEADCAFE};
      vt[3]  = '{1'b0, 32'h0000_4014, 4'h0, 32'h0,         32'hDEADCAFE};
      vt[4]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h12345678,  32'h0};
      vt[5]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h12345678};
      vt[6]  = '{1'b1, 32'h0000_0021, 4'h0, 32'hFFFFFFFF,  32'h0};
      vt[7]  = '{1'b0, 32'h0000_0023, 4'h0, 32'h0,         32'h12345678};
      vt[8]  = '{1'b1, 32'h0000_0020, 4'h8, 32'hA5000000,  32'h0};
      vt[9]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'hA5345678};
      vt[10] = '{1'b0, 32'h000F_FFFC, 4'h0, 32'h0,         32'hFACEFEED};

      #1;
      chk("reset_ready", {31'd0, cresp.ready}, 32'd0);
      chk("reset_last",  {31'd0, cresp.last},  32'd0);
      chk("reset_data",  cresp.data,           32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         wbuf[0] = vt[i].wdata;
         sbuf[0] = vt[i].strobe;
         burst(vt[i].w, vt[i].addr, 4'd0, CBUS_BURST_FIXED);
         if (!vt[i].w) chk($sformatf("vec%0d_rdata", i), rbuf[0], vt[i].exp);
      end

      for (int i = 0; i < 4; i++) begin
         wbuf[i] = i + 1;
         sbuf[i] = 4'hF;
      end
      burst(1'b1, 32'h40, 4'd3, CBUS_BURST_INCR);
      burst(1'b0, 32'h40, 4'd3, CBUS_BURST_INCR);
      for (int i = 0; i < 4; i++) chk($sformatf("incr_wr_mem%0d", 16 + i), rbuf[i], i + 1);

      wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0001;
      wbuf[1] = 32'h00EE0000; sbuf[1] = 4'b0100;
      burst(1'b1, 32'h0, 4'd1, CBUS_BURST_FIXED);
      burst(1'b0, 32'h0, 4'd0, CBUS_BURST_FIXED);
      chk("fixed_strobe_mem0", rbuf[0], 32'h11EE33DD);

      burst(1'b0, 32'h3FFC, 4'd1, CBUS_BURST_INCR);
      chk("wrap_beat0", rbuf[0], 32'hFACEFEED);
      chk("wrap_beat1", rbuf[1], 32'h11EE33DD);

      creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = 32'h100;
      creq.len = 4'd7; creq.burst = CBUS_BURST_INCR;
      @(posedge clk); #1;
      creq.valid = 1'b0;
      cnt = 0;
      for (int c = 0; c < 200 && cnt < 3; c++) begin
         @(negedge clk);
         if (cresp.ready) cnt++;
      end
      chk("rst_burst_progress", cnt, 3);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_ready", {31'd0, cresp.ready}, 32'd0);
      chk("rst_mid_last",  {31'd0, cresp.last},  32'd0);
      chk("rst_mid_data",  cresp.data,           32'd0);
      @(negedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rst_post_idle_ready", {31'd0, cresp.ready}, 32'd0);
      end
      @(posedge clk); #1;
      burst(1'b0, 32'h14, 4'd0, CBUS_BURST_FIXED);
      chk("rst_then_read", rbuf[0], 32'hDEADCAFE);

`ifdef CBUS_RESP_RANDOM_STALL_EN
      n_rand = 1000;
`else
      n_rand = 40;
`endif
      for (int t = 0; t < n_rand; t++) begin
         for (int k = 0; k < 16; k++) begin
            wbuf[k] = $urandom;
            sbuf[k] = 4'($urandom_range(0, 15));
         end
         burst(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 1) != 0) ? CBUS_BURST_INCR : CBUS_BURST_FIXED);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cbus_mem_responder.md
# cbus_mem_responder

CBus responder (slave end of the cache-bus protocol) backing a word-addressed on-chip memory. Accepts the `cbus_req_t` issued by the CBus arbiter after address translation, performs single or burst reads/writes with a programmable initial latency, and returns `cbus_resp_t` beats with `ready`/`last`. Used as the memory model behind the core's `oreq`/`oresp` port and as a device stub in bring-up.

## Interface
Parameters:
- `SIZE_WORDS`, 4096: memory depth in 32-bit words; power of two.
- `LATENCY`, 2: idle cycles between request acceptance and the first beat; 0..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `creq`  in  `cbus_req_t`  fields used: `valid`, `is_write`, `addr`, `strobe` (4), `data` (32), `len` (`cbus_len_t`, beats = len+1, 1..16), `burst` (FIXED / INCR). `size` is ignored.
- `cresp`  out  `cbus_resp_t`  `ready` (beat completes), `last` (final beat), `data` (32, read data).

## Operation
- FSM states: IDLE, WAIT, BEAT.
- IDLE: if `creq.valid`, latch `addr`, `is_write`, `len`, `burst`; load word index = `addr[log2(SIZE_WORDS)+1:2]`; load latency counter with LATENCY; go to WAIT (or BEAT if LATENCY=0).
- WAIT: decrement counter each cycle; at 0 go to BEAT.
- BEAT: `cresp.ready`=1 each cycle a beat completes. Read beat: `cresp.data` = mem[index]. Write beat: for each byte b with `creq.strobe[b]`=1, mem[index] byte b <= `creq.data` byte b; other bytes unchanged. `data`/`strobe` are sampled per beat, all other fields only at acceptance.
- Beat counter counts 0..len; `cresp.last`=1 with `ready` on beat len; next state IDLE.
- INCR: index += 1 per beat, wrapping modulo SIZE_WORDS. FIXED: index constant.
- `addr[1:0]` ignored; out-of-range addresses alias modulo SIZE_WORDS.
- `creq.valid` dropping mid-transaction is a protocol violation; responder completes the burst regardless.
- Memory contents are not cleared by reset; bench preloads via hierarchical access.

## Timing
- Reset (any state, any cycle): FSM -> IDLE, counters 0, `cresp.ready`=0, `cresp.last`=0, `cresp.data`=0. In-flight writes already committed stay committed; remaining beats are dropped.
- Acceptance at edge t (IDLE, valid=1): first beat `ready`=1 in cycle t+1+LATENCY.
- Without stalls, beats of one burst are back-to-back: len+1 consecutive `ready` cycles; `last` only on the final one.
- Read data is valid in the same cycle as `ready`; write commits at the edge ending the `ready` cycle.
- After `last`, FSM is IDLE; a `valid` seen in that next cycle is a new request (requester deasserts valid in the cycle after `last`). Minimum spacing between transactions: `last` cycle, then one IDLE cycle.
- `ready`/`last`/`data` are 0 in IDLE and WAIT.

## Configuration
- `CBUS_RESP_RANDOM_STALL_EN`: defined -> a 16-bit LFSR (seed 16'hACE1 on reset) gates BEAT; when LFSR bit 0 is 1 the cycle is a stall (`ready`=0, no beat advance, no write). LFSR steps every cycle. Undefined -> no LFSR, beats never stall; behaviour exactly as above.

## Test plan
- Reset: assert `reset` mid-burst of a len=7 read -> `ready`/`last`/`data` 0 same cycle; FSM in IDLE; next request served normally.
- Single read, LATENCY=2: mem[5]=32'hDEADBEEF, request addr 32'h14 len=0 at edge t -> `ready`=`last`=1, `data`=32'hDEADBEEF in cycle t+3 only.
- INCR write burst: addr 32'h40, len=3, data 1,2,3,4, strobe 4'hF -> 4 ready cycles, last on 4th; mem[16..19]=1,2,3,4.
- Strobe/FIXED: mem[0]=32'h11223344, FIXED write len=1 addr 0, beat0 data 32'hAABBCCDD strobe 4'b0001, beat1 data 32'h00EE0000 strobe 4'b0100 -> mem[0]=32'h11EE33DD.
- Wrap: SIZE_WORDS=4096, INCR read len=1 at addr 32'h3FFC -> beats return mem[4095], then mem[0].
- Back-to-back: second request held valid immediately after `last` -> accepted in the following cycle, first beat LATENCY+1 cycles later; with `CBUS_RESP_RANDOM_STALL_EN`, 1000 random bursts match a scoreboard.
